// File: rtl/aes_io_bridge_if.sv
// Pin-side and core-side signal bundle for the AES byte/word bridge.
// The slave modport is the bridge itself; the master modport is whoever drives it.
interface aes_io_bridge_if #(
  parameter int IN_W   = 8,
  parameter int OUT_W  = 8,
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4,
  parameter int DIV_W  = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              shi;
  logic [IN_W-1:0]   in_data;
  logic              msb_first;
  logic              flush;
  logic [WORD_W-1:0] up_word;
  logic              up_valid;
  logic              up_ready;
  logic [LVL_W-1:0]  in_level;
  logic              overflow;
  logic [WORD_W-1:0] down_word;
  logic              down_valid;
  logic              down_ready;
  logic [DIV_W-1:0]  div_bits;
  logic [OUT_W-1:0]  chip_data;
  logic              sho;

  modport slave (
    input  shi, in_data, msb_first, flush, up_ready, down_word, down_valid, div_bits,
    output up_word, up_valid, in_level, overflow, down_ready, chip_data, sho
  );

  modport master (
    output shi, in_data, msb_first, flush, up_ready, down_word, down_valid, div_bits,
    input  up_word, up_valid, in_level, overflow, down_ready, chip_data, sho
  );
endinterface

// File: rtl/aes_io_bridge.sv
// Byte-stream <-> word bridge: packs input lanes into words held in a small
// first-word-fall-through FIFO, and serialises result words into output lanes
// at a programmable lane period.
module aes_io_bridge #(
  parameter int IN_W   = 8,
  parameter int OUT_W  = 8,
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4,
  parameter int DIV_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  aes_io_bridge_if.slave  bus
);
  localparam int RI    = WORD_W / IN_W;
  localparam int RO    = WORD_W / OUT_W;
  localparam int CNT_W = (RI > 1) ? $clog2(RI) : 1;
  localparam int IDX_W = (RO > 1) ? $clog2(RO) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(RI - 1);
  localparam logic [IDX_W-1:0] LAST_OUT = IDX_W'(RO - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  // ---------------- packer + input FIFO ----------------
  logic [WORD_W-1:0] pack_reg;
  logic [WORD_W-1:0] pack_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  lane_in;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [LVL_W-1:0]  level_reg;
  logic              overflow_reg;
  logic              push;
  logic              pop;
  logic              full;
  logic              accept;

  // Merge the incoming lane into the partial word; the completed word is pushed straight from here
  always_comb begin
    lane_in   = bus.msb_first ? (LAST_IN - cnt_reg) : cnt_reg;
    pack_next = pack_reg;
    pack_next[lane_in*IN_W +: IN_W] = bus.in_data;
  end

  assign push   = bus.shi && (cnt_reg == LAST_IN) && !bus.flush;
  assign pop    = bus.up_ready && (level_reg != '0) && !bus.flush;
  assign full   = (level_reg == FULL_LVL);
  // A pop in the same cycle frees the slot the push needs
  assign accept = push && (!full || pop);

  // Lane counter and partial word; flush and reset abandon any partial word
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      cnt_reg  <= '0;
      pack_reg <= '0;
    end else if (bus.shi) begin
      pack_reg <= pack_next;
      cnt_reg  <= (cnt_reg == LAST_IN) ? '0 : cnt_reg + 1'b1;
    end
  end

  // FIFO storage, written only when the push is accepted
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_reg] <= pack_next;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (accept && !pop)      level_reg <= level_reg + 1'b1;
      else if (!accept && pop) level_reg <= level_reg - 1'b1;
      if (push && !accept) overflow_reg <= 1'b1;
    end
  end

  // Head word is masked while empty so stale RAM contents never leak out
  assign bus.up_valid = (level_reg != '0);
  assign bus.up_word  = bus.up_valid ? mem[rd_ptr_reg] : '0;
  assign bus.in_level = level_reg;
  assign bus.overflow = overflow_reg;

  // ---------------- output serialiser ----------------
  logic [0:0]        state_reg;
  logic [WORD_W-1:0] sword_reg;
  logic              smsb_reg;
  logic [DIV_W-1:0]  div_reg;
  logic [DIV_W-1:0]  tmr_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [IDX_W-1:0]  lane_out;
  logic [OUT_W-1:0]  chip_reg;
  logic              sho_reg;

  assign lane_out = smsb_reg ? (LAST_OUT - idx_reg) : idx_reg;

  // Serialiser FSM: latch a word in IDLE, then issue one lane every D+1 cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sword_reg <= '0;
      smsb_reg  <= 1'b0;
      div_reg   <= '0;
      tmr_reg   <= '0;
      idx_reg   <= '0;
      chip_reg  <= '0;
      sho_reg   <= 1'b0;
    end else begin
      sho_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.down_valid) begin
            sword_reg <= bus.down_word;
            smsb_reg  <= bus.msb_first;
            div_reg   <= bus.div_bits;
            tmr_reg   <= bus.div_bits;
            idx_reg   <= '0;
            state_reg <= SEND;
          end
        end
        SEND: begin
          if (tmr_reg != '0) begin
            tmr_reg <= tmr_reg - 1'b1;
          end else begin
            chip_reg <= sword_reg[lane_out*OUT_W +: OUT_W];
            sho_reg  <= 1'b1;
            tmr_reg  <= div_reg;
            idx_reg  <= idx_reg + 1'b1;
            if (idx_reg == LAST_OUT) state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.down_ready = (state_reg == IDLE);
  assign bus.chip_data  = chip_reg;
  assign bus.sho        = sho_reg;
endmodule

// File: tb/tb_aes_io_bridge.sv
// Directed bench for aes_io_bridge: packing in both lane orders, FIFO full /
// overflow / flush behaviour, and serialiser timing, order and reset abort.
module tb_aes_io_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  aes_io_bridge_if #(.IN_W(8), .OUT_W(8), .WORD_W(32), .DEPTH(4), .DIV_W(4)) bus ();

  aes_io_bridge #(.IN_W(8), .OUT_W(8), .WORD_W(32), .DEPTH(4), .DIV_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input logic [31:0] seq);
    for (int i = 0; i < 4; i++) begin
      bus.shi     = 1'b1;
      bus.in_data = seq[31-8*i -: 8];
      step();
    end
    bus.shi = 1'b0;
    $display("[TB] sent bytes %h", seq);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests_run++; if (bus.up_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_up_valid got %b want 0", bus.up_valid); end
    tests_run++; if (bus.up_word !== 32'h0) begin tests_failed++; $display("FAIL reset_up_word got %h want 0", bus.up_word); end
    tests_run++; if (bus.in_level !== 3'd0) begin tests_failed++; $display("FAIL reset_in_level got %0d want 0", bus.in_level); end
    tests_run++; if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    tests_run++; if (bus.down_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_down_ready got %b want 1", bus.down_ready); end
    tests_run++; if (bus.chip_data !== 8'h0) begin tests_failed++; $display("FAIL reset_chip_data got %h want 0", bus.chip_data); end
    tests_run++; if (bus.sho !== 1'b0) begin tests_failed++; $display("FAIL reset_sho got %b want 0", bus.sho); end
    rst = 1'b0;
    step();
    $display("[TB] reset done");
  endtask

  task automatic pop_one();
    bus.up_ready = 1'b1;
    step();
    bus.up_ready = 1'b0;
  endtask

  task automatic test_pack_msb();
    bus.msb_first = 1'b1;
    send_bytes(32'h11223344);
    tests_run++; if (bus.up_word !== 32'h11223344) begin tests_failed++; $display("FAIL pack_msb_word got %h want 11223344", bus.up_word); end
    tests_run++; if (bus.up_valid !== 1'b1) begin tests_failed++; $display("FAIL pack_msb_valid got %b want 1", bus.up_valid); end
    tests_run++; if (bus.in_level !== 3'd1) begin tests_failed++; $display("FAIL pack_msb_level got %0d want 1", bus.in_level); end
    pop_one();
    tests_run++; if (bus.in_level !== 3'd0) begin tests_failed++; $display("FAIL pack_msb_pop_level got %0d want 0", bus.in_level); end
  endtask

  task automatic test_pack_lsb();
    bus.msb_first = 1'b0;
    send_bytes(32'h11223344);
    tests_run++; if (bus.up_word !== 32'h44332211) begin tests_failed++; $display("FAIL pack_lsb_word got %h want 44332211", bus.up_word); end
    pop_one();
    tests_run++; if (bus.up_valid !== 1'b0) begin tests_failed++; $display("FAIL pack_lsb_pop_valid got %b want 0", bus.up_valid); end
  endtask

  task automatic test_overflow_flush();
    logic [31:0] words [5];
    words = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'h11121314};
    bus.msb_first = 1'b1;
    for (int k = 0; k < 4; k++) send_bytes(words[k]);
    tests_run++; if (bus.in_level !== 3'd4) begin tests_failed++; $display("FAIL ovf_level4 got %0d want 4", bus.in_level); end
    tests_run++; if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_early got %b want 0", bus.overflow); end
    send_bytes(words[4]);
    tests_run++; if (bus.in_level !== 3'd4) begin tests_failed++; $display("FAIL ovf_level_after got %0d want 4", bus.in_level); end
    tests_run++; if (bus.overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky got %b want 1", bus.overflow); end
    tests_run++; if (bus.up_word !== 32'h01020304) begin tests_failed++; $display("FAIL ovf_head got %h want 01020304", bus.up_word); end
    // flush with a concurrent strobe: the strobe must be ignored
    bus.flush   = 1'b1;
    bus.shi     = 1'b1;
    bus.in_data = 8'hEE;
    step();
    bus.flush = 1'b0;
    bus.shi   = 1'b0;
    tests_run++; if (bus.in_level !== 3'd0) begin tests_failed++; $display("FAIL flush_level got %0d want 0", bus.in_level); end
    tests_run++; if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL flush_overflow got %b want 0", bus.overflow); end
    tests_run++; if (bus.up_word !== 32'h0) begin tests_failed++; $display("FAIL flush_up_word got %h want 0", bus.up_word); end
    send_bytes(32'hDEADBEEF);
    tests_run++; if (bus.up_word !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL flush_realign got %h want deadbeef", bus.up_word); end
    pop_one();
  endtask

  task automatic test_full_pop();
    logic [31:0] words [5];
    words = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3, 32'hE0E1E2E3};
    bus.msb_first = 1'b1;
    for (int k = 0; k < 4; k++) send_bytes(words[k]);
    for (int i = 0; i < 4; i++) begin
      bus.shi      = 1'b1;
      bus.in_data  = words[4][31-8*i -: 8];
      bus.up_ready = (i == 3);
      step();
    end
    bus.shi      = 1'b0;
    bus.up_ready = 1'b0;
    tests_run++; if (bus.in_level !== 3'd4) begin tests_failed++; $display("FAIL fullpop_level got %0d want 4", bus.in_level); end
    tests_run++; if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL fullpop_overflow got %b want 0", bus.overflow); end
    for (int k = 1; k < 5; k++) begin
      tests_run++; if (bus.up_word !== words[k]) begin tests_failed++; $display("FAIL fullpop_head%0d got %h want %h", k, bus.up_word, words[k]); end
      pop_one();
    end
    tests_run++; if (bus.in_level !== 3'd0) begin tests_failed++; $display("FAIL fullpop_drained got %0d want 0", bus.in_level); end
    pop_one();
    tests_run++; if (bus.in_level !== 3'd0) begin tests_failed++; $display("FAIL empty_pop_level got %0d want 0", bus.in_level); end
    $display("[TB] full-with-pop sequence done");
  endtask

  task automatic test_serial_d0();
    logic [7:0] exp [4];
    exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    tests_run++; if (bus.down_ready !== 1'b1) begin tests_failed++; $display("FAIL ser0_ready_idle got %b want 1", bus.down_ready); end
    bus.down_word  = 32'hA1B2C3D4;
    bus.div_bits   = 4'd0;
    bus.msb_first  = 1'b1;
    bus.down_valid = 1'b1;
    step();
    bus.down_valid = 1'b0;
    tests_run++; if (bus.sho !== 1'b0 || bus.down_ready !== 1'b0) begin tests_failed++; $display("FAIL ser0_after_xfer got sho=%b rdy=%b want 0 0", bus.sho, bus.down_ready); end
    for (int k = 0; k < 4; k++) begin
      step();
      tests_run++; if (bus.sho !== 1'b1 || bus.chip_data !== exp[k]) begin tests_failed++; $display("FAIL ser0_lane%0d got sho=%b data=%h want 1 %h", k, bus.sho, bus.chip_data, exp[k]); end
      if (k < 3) begin
        tests_run++; if (bus.down_ready !== 1'b0) begin tests_failed++; $display("FAIL ser0_busy%0d got %b want 0", k, bus.down_ready); end
      end
    end
    step();
    tests_run++; if (bus.sho !== 1'b0 || bus.down_ready !== 1'b1 || bus.chip_data !== 8'hD4) begin tests_failed++; $display("FAIL ser0_end got sho=%b rdy=%b data=%h want 0 1 d4", bus.sho, bus.down_ready, bus.chip_data); end
    $display("[TB] serialised a1b2c3d4 at div 0");
  endtask

  task automatic test_serial_lsb_d1();
    logic [7:0] exp [4];
    exp = '{8'h78, 8'h56, 8'h34, 8'h12};
    bus.down_word  = 32'h12345678;
    bus.div_bits   = 4'd1;
    bus.msb_first  = 1'b0;
    bus.down_valid = 1'b1;
    step();
    bus.down_valid = 1'b0;
    bus.msb_first  = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      tests_run++; if (bus.sho !== ((c % 2) == 0)) begin tests_failed++; $display("FAIL ser1_sho_c%0d got %b want %b", c, bus.sho, ((c % 2) == 0)); end
      if ((c % 2) == 0) begin
        tests_run++; if (bus.chip_data !== exp[c/2-1]) begin tests_failed++; $display("FAIL ser1_data_c%0d got %h want %h", c, bus.chip_data, exp[c/2-1]); end
      end
    end
    bus.msb_first = 1'b0;
    $display("[TB] serialised 12345678 lsb-first at div 1");
  endtask

  task automatic test_serial_d2_reset();
    bus.down_word  = 32'hCAFEBABE;
    bus.div_bits   = 4'd2;
    bus.msb_first  = 1'b1;
    bus.down_valid = 1'b1;
    step();
    bus.down_valid = 1'b0;
    bus.div_bits   = 4'd0;
    for (int c = 1; c <= 6; c++) begin
      step();
      tests_run++; if (bus.sho !== (c == 3 || c == 6)) begin tests_failed++; $display("FAIL ser2_sho_c%0d got %b want %b", c, bus.sho, (c == 3 || c == 6)); end
      if (c == 3) begin
        tests_run++; if (bus.chip_data !== 8'hCA) begin tests_failed++; $display("FAIL ser2_lane0 got %h want ca", bus.chip_data); end
      end
      if (c == 6) begin
        tests_run++; if (bus.chip_data !== 8'hFE) begin tests_failed++; $display("FAIL ser2_lane1 got %h want fe", bus.chip_data); end
      end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++; if (bus.sho !== 1'b0 || bus.down_ready !== 1'b1 || bus.chip_data !== 8'h0) begin tests_failed++; $display("FAIL ser2_reset got sho=%b rdy=%b data=%h want 0 1 00", bus.sho, bus.down_ready, bus.chip_data); end
    for (int c = 0; c < 6; c++) begin
      step();
      tests_run++; if (bus.sho !== 1'b0) begin tests_failed++; $display("FAIL ser2_quiet_c%0d got %b want 0", c, bus.sho); end
    end
    $display("[TB] div 2 send aborted by reset");
  endtask

  initial begin
    bus.shi        = 1'b0;
    bus.in_data    = '0;
    bus.msb_first  = 1'b1;
    bus.flush      = 1'b0;
    bus.up_ready   = 1'b0;
    bus.down_word  = '0;
    bus.down_valid = 1'b0;
    bus.div_bits   = '0;
    test_reset();
    test_pack_msb();
    test_pack_lsb();
    test_overflow_flush();
    test_full_pop();
    test_serial_d0();
    test_serial_lsb_d1();
    test_serial_d2_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
